least_served_arbiter: RTL and testbench
=======================================

Name: least_served_arbiter

Overview:
- Sequential fairness arbiter for shared resources in the VC-based mesh router, such as an output port or a VC pool.
- Keeps one service counter per requester and grants the active requester served least often; ties go to the lowest index.
- Selection reuses the team's combinational minimum-number finder (one-hot, lowest-index tie-break) on masked counter keys.
- The grant is held until the owner pulses release.

Parameters:
- NUM_OF_INPUTS, 8, number of requesters (≥1).
- CNT_WIDTH, 5, width of each service counter.
- IDX_WIDTH, log2 of NUM_OF_INPUTS (min 1), width of grant_index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  NUM_OF_INPUTS  per-requester request level.
- release  input  1  single-cycle pulse from the current owner; frees the resource.
- grant  output  NUM_OF_INPUTS  registered one-hot grant.
- grant_valid  output  1  high while any grant is held.
- grant_index  output  IDX_WIDTH  binary index of the granted requester; 0 when grant_valid=0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: grant=0, grant_valid=0, grant_index=0, all counters=0, state=IDLE.
- Reset asserted mid-BUSY: all outputs are 0 on the next cycle, and the in-flight grant is dropped without any counter update.
- Selection key per input i is {~request[i], count[i]}, which is CNT_WIDTH+1 bits. A non-requester can never beat a requester, even one at the all-ones count.
- The minimum finder runs on these keys. Its one-hot result is valid only when |request=1.
- States are IDLE and BUSY.
- IDLE, |request=0: stay in IDLE; outputs remain 0.
- IDLE, |request=1: register the winner into grant/grant_index, set grant_valid=1, go to BUSY. Latency is 1 cycle: request sampled at edge k, grant visible after edge k.
- Counter update happens in the same edge as the grant, winner only:
  - If count[w] < 2^CNT_WIDTH-1: count[w] += 1.
  - Otherwise (saturation): every count[j] is shifted right by 1, then count[w] is set to 2^(CNT_WIDTH-1). This preserves relative ordering and avoids wrap-around.
- BUSY, release=0: hold grant unchanged. Changes on request, including the owner dropping its request, are ignored.
- BUSY, release=1: clear grant, grant_valid and grant_index at the next edge; go to IDLE. There is always exactly one idle cycle between consecutive grants, and arbitration for the next grant uses the updated counters.
- release while in IDLE is ignored.
- release and a new request in the same cycle: the request is evaluated only in the following IDLE cycle.
- NUM_OF_INPUTS=1: arbiter degenerates to grant=request[0] under the same IDLE/BUSY/release protocol; the counter is kept but has no effect.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - grant_index matches grant.
  - No grant is ever issued to an input whose request was 0 in the arbitration cycle.

Test Plan:
(all with NUM_OF_INPUTS=4, CNT_WIDTH=3)
- Reset, then request=4'b1111 held, with release pulsed 2 cycles after each grant -> grant sequence 0001,0010,0100,1000,0001. Each grant appears 1 cycle after its IDLE cycle; grant_index is 0,1,2,3,0.
- request=4'b0001 for 3 grants, then request=4'b0011 -> grants 0010 three times (count1 reaches 3, tie), then 0001 on the tie.
- Saturation: request=4'b0100 alone for 8 grants -> after the 8th grant, count2=4 and the others are 0. Then request=4'b0101 -> input 0 is granted 4 times, then input 0 again on the tie at 4.
- request drops to 0 while in BUSY, no release for 10 cycles -> grant stays 0100 and grant_valid stays 1. After release, grant=0 and grant_valid=0 on the next edge.
- release pulsed in IDLE with request=0 -> no state change, all outputs 0. Release together with request=4'b1000 in BUSY -> one idle cycle, then grant=1000.
- reset asserted while grant=0010 -> next cycle grant=0 and grant_valid=0. A subsequent request=4'b1111 -> grant=0001, confirming the counters were cleared.

Source files
------------

// File: rtl/least_served_arbiter.sv
// ---------------------------------------------------------------------------
// least_served_arbiter
//
// Fairness arbiter for a shared router resource (output port, VC pool).
// Each requester has a service counter. When the resource is free, the active
// requester with the lowest count wins. On a tie, the lowest index wins. The
// grant is held until the current owner pulses release_pulse.
//
// Ports:
//   clk            system clock, rising-edge
//   reset          synchronous, active-high reset
//   request        per-requester request level   [NUM_OF_INPUTS]
//   release_pulse  one-cycle pulse from the owner that frees the resource
//   grant          registered one-hot grant      [NUM_OF_INPUTS]
//   grant_valid    high while a grant is held
//   grant_index    binary index of the granted requester, 0 when idle
//
// The release input is called release_pulse because "release" is a reserved
// word in SystemVerilog.
// ---------------------------------------------------------------------------
module least_served_arbiter #(
    parameter int NUM_OF_INPUTS = 8,
    parameter int CNT_WIDTH     = 5,
    parameter int IDX_WIDTH     = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_OF_INPUTS-1:0] request,
    input  logic                     release_pulse,
    output logic [NUM_OF_INPUTS-1:0] grant,
    output logic                     grant_valid,
    output logic [IDX_WIDTH-1:0]     grant_index
);

    // After saturation the winner is set to half scale. The other counters
    // are halved, so they all end up below it and keep their relative order.
    localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_reg;

    logic [CNT_WIDTH-1:0]     count    [NUM_OF_INPUTS];
    logic [CNT_WIDTH:0]       key      [NUM_OF_INPUTS];
    logic [NUM_OF_INPUTS-1:0] winner_onehot;
    logic [NUM_OF_INPUTS-1:0] sat_vec;
    logic [IDX_WIDTH-1:0]     winner_index;
    logic                     winner_saturated;
    logic                     arbitrate;

    // An arbitration happens only in IDLE with at least one active request.
    assign arbitrate = (state_reg == IDLE) && (|request);

    // -----------------------------------------------------------------------
    // Per-requester service counters and selection keys.
    // The inverted request bit is the key MSB. Any non-requester therefore
    // sorts after every requester, including one at the all-ones count.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_OF_INPUTS; gi++) begin : g_counter
            logic [CNT_WIDTH-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (arbitrate) begin
                    if (winner_saturated) begin
                        count_reg <= winner_onehot[gi] ? CNT_HALF : (count_reg >> 1);
                    end else if (winner_onehot[gi]) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
            end

            assign count[gi]   = count_reg;
            assign key[gi]     = {~request[gi], count_reg};
            assign sat_vec[gi] = &count_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Minimum finder. Input gi wins when its key is strictly below every
    // lower-indexed key and no greater than every higher-indexed key. This
    // gives exactly one winner, with ties going to the lowest index. The
    // result is only meaningful when at least one request is active.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_OF_INPUTS; gi++) begin : g_min_finder
            logic beats_all;

            always_comb begin
                beats_all = 1'b1;
                for (int j = 0; j < NUM_OF_INPUTS; j++) begin
                    if (j < gi) begin
                        beats_all = beats_all & (key[gi] < key[j]);
                    end else if (j > gi) begin
                        beats_all = beats_all & (key[gi] <= key[j]);
                    end
                end
            end

            assign winner_onehot[gi] = beats_all;
        end
    endgenerate

    // One-hot to binary conversion of the winner.
    always_comb begin
        winner_index = '0;
        for (int i = 0; i < NUM_OF_INPUTS; i++) begin
            if (winner_onehot[i]) begin
                winner_index = winner_index | IDX_WIDTH'(i);
            end
        end
    end

    // Saturation is judged on the winner's count only.
    assign winner_saturated = |(winner_onehot & sat_vec);

    // -----------------------------------------------------------------------
    // IDLE/BUSY control with registered outputs.
    // In BUSY, request changes are ignored. This includes the owner dropping
    // its request. Only release_pulse frees the resource, and the following
    // IDLE cycle always separates two grants.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|request) begin
                        grant       <= winner_onehot;
                        grant_index <= winner_index;
                        grant_valid <= 1'b1;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_pulse) begin
                        grant       <= '0;
                        grant_index <= '0;
                        grant_valid <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_least_served_arbiter.sv
// ---------------------------------------------------------------------------
// tb_least_served_arbiter
//
// Bench for least_served_arbiter with NUM_OF_INPUTS=4 and CNT_WIDTH=3.
// It applies a table of vectors for the round-robin-like startup, then
// hand-written multi-cycle sequences, then random traffic. A behavioural
// model (a plain array of service counts plus a busy flag) follows every
// clock edge, and the DUT outputs are compared with it after each edge.
// ---------------------------------------------------------------------------
module tb_least_served_arbiter;

    localparam int N       = 4;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int CNT_MID = 1 << (CW - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] request;
    logic         release_pulse;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_index;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Behavioural model state
    int         mcnt [N];
    logic       mbusy;
    logic [3:0] mgrant;
    logic       mvalid;
    logic [1:0] midx;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic [3:0] exp_grant;
        logic       exp_valid;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t tbl [16];

    least_served_arbiter #(
        .NUM_OF_INPUTS(N),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .release_pulse(release_pulse),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_index  (grant_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d: got %b want %b", name, cycle_no, act, exp);
        end
    endtask

    // Reference behaviour: the least-served active requester wins, with the
    // lowest index winning ties. On saturation all counts are halved and the
    // winner is set to half scale.
    task automatic model_edge();
        int w;
        if (reset) begin
            for (int i = 0; i < N; i++) mcnt[i] = 0;
            mbusy  = 1'b0;
            mgrant = '0;
            mvalid = 1'b0;
            midx   = '0;
        end else if (!mbusy) begin
            if (request != 0) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (request[i] && (w < 0 || mcnt[i] < mcnt[w])) w = i;
                end
                mgrant = 4'(1 << w);
                midx   = 2'(w);
                mvalid = 1'b1;
                mbusy  = 1'b1;
                if (mcnt[w] == CNT_MAX) begin
                    for (int j = 0; j < N; j++) mcnt[j] = mcnt[j] / 2;
                    mcnt[w] = CNT_MID;
                end else begin
                    mcnt[w] = mcnt[w] + 1;
                end
                $display("cycle=%0d req=%b grant idx=%0d counts=%0d,%0d,%0d,%0d",
                         cycle_no, request, w, mcnt[0], mcnt[1], mcnt[2], mcnt[3]);
            end
        end else if (release_pulse) begin
            mbusy  = 1'b0;
            mgrant = '0;
            mvalid = 1'b0;
            midx   = '0;
        end
    endtask

    // One clock: the model follows the edge, then the DUT is compared 1 time
    // unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        cycle_no++;
        #1;
        check("model_grant", grant, mgrant);
        check("model_valid", {3'b000, grant_valid}, {3'b000, mvalid});
        check("model_index", {2'b00, grant_index}, {2'b00, midx});
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        request       = '0;
        release_pulse = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Arbitrate one grant with a constant expectation, then release it.
    task automatic do_grant(input logic [3:0] req, input logic [3:0] exp, input string name);
        request       = req;
        release_pulse = 1'b0;
        step();
        check(name, grant, exp);
        release_pulse = 1'b1;
        step();
        check({name, "_clear"}, {grant_valid, grant[2:0]}, 4'b0000);
        release_pulse = 1'b0;
    endtask

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] one_hot;

        reset         = 1'b1;
        request       = '0;
        release_pulse = 1'b0;

        // ---- Table: reset, then 1111 held, release 2 cycles after each grant
        tbl[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        for (int k = 0; k < 5; k++) begin
            one_hot      = 4'(1 << seq[k]);
            tbl[1+3*k]   = '{1'b0, 4'b1111, 1'b0, one_hot, 1'b1, 2'(seq[k])};
            tbl[2+3*k]   = '{1'b0, 4'b1111, 1'b0, one_hot, 1'b1, 2'(seq[k])};
            tbl[3+3*k]   = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        end
        for (int r = 0; r < 16; r++) begin
            reset         = tbl[r].rst;
            request       = tbl[r].req;
            release_pulse = tbl[r].rel;
            step();
            check("tbl_grant", grant, tbl[r].exp_grant);
            check("tbl_valid", {3'b000, grant_valid}, {3'b000, tbl[r].exp_valid});
            check("tbl_index", {2'b00, grant_index}, {2'b00, tbl[r].exp_idx});
        end

        // ---- Tie behaviour after unequal service
        do_reset();
        for (int k = 0; k < 3; k++) do_grant(4'b0001, 4'b0001, "tie_pre");
        for (int k = 0; k < 3; k++) do_grant(4'b0011, 4'b0010, "tie_catchup");
        do_grant(4'b0011, 4'b0001, "tie_low_index");

        // ---- Saturation: input 2 is served 8 times, so its count becomes 4
        do_reset();
        for (int k = 0; k < 8; k++) do_grant(4'b0100, 4'b0100, "sat_fill");
        for (int k = 0; k < 4; k++) do_grant(4'b0101, 4'b0001, "sat_catchup");
        do_grant(4'b0101, 4'b0001, "sat_tie");

        // ---- Owner drops its request in BUSY without releasing
        do_reset();
        request = 4'b0100;
        step();
        check("hold_grant", grant, 4'b0100);
        request = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_grant", grant, 4'b0100);
            check("hold_valid", {3'b000, grant_valid}, 4'b0001);
        end
        release_pulse = 1'b1;
        step();
        check("hold_release", {grant_valid, grant[2:0]}, 4'b0000);
        release_pulse = 1'b0;

        // ---- Release in IDLE is ignored. A release together with a new
        //      request leaves one idle cycle before the next grant.
        release_pulse = 1'b1;
        request       = '0;
        step();
        check("idle_release", {grant_valid, grant[2:0]}, 4'b0000);
        release_pulse = 1'b0;
        request       = 4'b0001;
        step();
        check("busy_grant", grant, 4'b0001);
        request       = 4'b1000;
        release_pulse = 1'b1;
        step();
        check("rel_req_idle", {grant_valid, grant[2:0]}, 4'b0000);
        check("rel_req_idle_g3", {3'b000, grant[3]}, 4'b0000);
        release_pulse = 1'b0;
        step();
        check("rel_req_grant", grant, 4'b1000);
        release_pulse = 1'b1;
        request       = '0;
        step();
        release_pulse = 1'b0;

        // ---- Reset mid-BUSY drops the grant and clears the counters
        do_reset();
        do_grant(4'b0001, 4'b0001, "rst_pre");
        do_grant(4'b0001, 4'b0001, "rst_pre");
        request = 4'b0010;
        step();
        check("rst_busy_grant", grant, 4'b0010);
        reset = 1'b1;
        step();
        check("rst_drop", grant, 4'b0000);
        check("rst_drop_valid", {3'b000, grant_valid}, 4'b0000);
        reset   = 1'b0;
        request = 4'b1111;
        step();
        check("rst_cleared", grant, 4'b0001);
        release_pulse = 1'b1;
        step();
        release_pulse = 1'b0;

        // ---- Random traffic checked against the model
        for (int k = 0; k < 3000; k++) begin
            request       = 4'($urandom_range(0, 15));
            release_pulse = ($urandom_range(0, 2) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            step();
            if (grant_valid) begin
                checks++;
                if (grant[grant_index] !== 1'b1) begin
                    failures++;
                    $display("FAIL onehot_index cycle=%0d: got grant=%b index=%0d want bit set",
                             cycle_no, grant, grant_index);
                end
            end
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
